hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage 16-bit core; sequences the PC, IF/ID, ID/EX and EX/MEM registers.
//  Detects load-use data hazards, taken branches/jumps resolved in ID, and the structural hazard on the
//  shared instruction/data RAM, when MEM-stage accesses to instruction RAM steal the port from IF.
//  Drives ifkeep/ifClear of the IF/ID register and arbitrates RAM ownership between IF and MEM.
// PARAMETERS
//  REG_W    4   register-index width
//  MEM_CYC  2   cycles one MEM access to instruction RAM occupies (>=1)
//  CNT_W    16  width of performance counters
// PORTS
//  clk          in   1      system clock; state updates on negedge, same edge as the pipeline registers
//  rst          in   1      asynchronous active-low reset
//  ex_memread   in   1      instruction in EX is a load
//  ex_rd        in   REG_W  destination register of EX instruction
//  id_rs        in   REG_W  source A of ID instruction
//  id_rs_use    in   1      ID instruction reads id_rs
//  id_rt        in   REG_W  source B of ID instruction
//  id_rt_use    in   1      ID instruction reads id_rt
//  branch_taken in   1      ID resolved a taken branch/jump this cycle
//  mem_req      in   1      MEM stage accesses instruction RAM this cycle
//  pc_keep      out  1      hold PC
//  ifkeep       out  1      hold IF/ID
//  ifClear      out  1      load NOP into IF/ID
//  idex_keep    out  1      hold ID/EX
//  idex_clear   out  1      load bubble into ID/EX
//  exmem_keep   out  1      hold EX/MEM
//  ram_owner    out  1      0 = IF owns RAM, 1 = MEM owns RAM
//  mem_done     out  1      final cycle of a MEM access
//  stall_cnt    out  CNT_W  stall-cycle counter (see CONFIGURATION)
//  flush_cnt    out  CNT_W  flush counter (see CONFIGURATION)
// BEHAVIOUR
//  - FSM states: S_RUN, S_MEM. Down-counter cnt: $clog2(MEM_CYC)+1 bits. Outputs are combinational from
//    state, cnt and inputs. While rst=0: state=S_RUN, cnt=0, every output 0.
//  - load_use = ex_memread & ((id_rs_use & ex_rd==id_rs) | (id_rt_use & ex_rd==id_rt)).
//  - Priority in S_RUN: mem_req > load_use > branch_taken.
//  - S_RUN, mem_req=1: ram_owner=1; pc_keep=ifkeep=idex_keep=1.
//    If MEM_CYC==1: mem_done=1, exmem_keep=0, stay in S_RUN.
//    Else: exmem_keep=1, cnt<=MEM_CYC-1, next state S_MEM.
//  - S_MEM: ram_owner=1; pc_keep=ifkeep=idex_keep=1; mem_req, load_use and branch_taken are ignored.
//    cnt>1: exmem_keep=1, cnt<=cnt-1.
//    cnt==1: mem_done=1, exmem_keep=0, cnt<=0, next state S_RUN.
//    Total ownership: exactly MEM_CYC cycles.
//  - S_RUN, !mem_req, load_use: pc_keep=ifkeep=idex_clear=1 for this cycle only. No state change; the
//    condition clears once the load advances.
//  - S_RUN, !mem_req, !load_use, branch_taken: ifClear=1; pc_keep=0, so PC loads the target.
//  - A branch masked by a stall is not lost: ID is held, so branch_taken re-presents after the stall.
//  - ifkeep and ifClear are never 1 together. idex_keep and idex_clear are never 1 together.
//  - Reset mid-access: state goes to S_RUN immediately, no mem_done pulse, ram_owner returns to 0.
// CONFIGURATION
//  - HAZ_PERF_CNT_EN defined: stall_cnt increments on every cycle with pc_keep=1. flush_cnt increments on
//    every cycle with ifClear=1. Both counters wrap modulo 2^CNT_W and reset to 0.
//  - HAZ_PERF_CNT_EN undefined: the ports remain, tied to 0, and no counter flops are built.
// TESTING
//  1. rst=0 asserted in 2nd cycle of S_MEM (MEM_CYC=3) -> all outputs 0 at once; after release, S_RUN with
//     ram_owner=0.
//  2. ex_memread=1, ex_rd=3, id_rs=3, id_rs_use=1 -> pc_keep=ifkeep=idex_clear=1 for one cycle. With
//     id_rs_use=0 -> all 0.
//  3. branch_taken=1, no hazards -> ifClear=1, pc_keep=0, ifkeep=0 that cycle only.
//  4. mem_req=1 held, MEM_CYC=2 -> 2 cycles of ram_owner=pc_keep=ifkeep=idex_keep=1. exmem_keep=1,0.
//     mem_done=0,1. Then S_RUN.
//  5. mem_req+load_use+branch_taken together, MEM_CYC=2 -> 2 mem-stall cycles with idex_clear=0, ifClear=0.
//     Then mem_req=0, load_use still 1 -> 1 load-use stall.
//  6. HAZ_PERF_CNT_EN: 3 load-use stalls, one MEM_CYC=2 access, 2 branches -> stall_cnt=5, flush_cnt=2.
//     Macro undefined -> both 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use, ID branch flush and shared-RAM arbitration.
// Optional perf counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int REG_W   = 4,
  parameter int MEM_CYC = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_use,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_use,
  input  logic             branch_taken,
  input  logic             mem_req,
  output logic             pc_keep,
  output logic             ifkeep,
  output logic             ifClear,
  output logic             idex_keep,
  output logic             idex_clear,
  output logic             exmem_keep,
  output logic             ram_owner,
  output logic             mem_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int CW = $clog2(MEM_CYC) + 1;
  localparam bit MULTI = (MEM_CYC > 1);

  typedef enum logic {S_RUN, S_MEM} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          load_use;

  assign load_use = ex_memread &
                    ((id_rs_use & (ex_rd == id_rs)) |
                     (id_rt_use & (ex_rd == id_rt)));

  // Pipeline registers move on the falling edge, so this does too.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      S_RUN: begin
        if (mem_req && MULTI) begin
          state_nx = S_MEM;
          cnt_nx   = CW'(MEM_CYC - 1);
        end
      end
      S_MEM: begin
        if (cnt > CW'(1)) begin
          cnt_nx = cnt - CW'(1);
        end else begin
          cnt_nx   = '0;
          state_nx = S_RUN;
        end
      end
      default: begin
        state_nx = S_RUN;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are gated by rst so an asserted reset silences them at once.
  always_comb begin
    pc_keep    = 1'b0;
    ifkeep     = 1'b0;
    ifClear    = 1'b0;
    idex_keep  = 1'b0;
    idex_clear = 1'b0;
    exmem_keep = 1'b0;
    ram_owner  = 1'b0;
    mem_done   = 1'b0;
    if (rst) begin
      unique case (state)
        S_RUN: begin
          priority case (1'b1)
            mem_req: begin
              ram_owner  = 1'b1;
              pc_keep    = 1'b1;
              ifkeep     = 1'b1;
              idex_keep  = 1'b1;
              mem_done   = !MULTI;
              exmem_keep = MULTI;
            end
            load_use: begin
              pc_keep    = 1'b1;
              ifkeep     = 1'b1;
              idex_clear = 1'b1;
            end
            branch_taken: begin
              ifClear = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          ram_owner  = 1'b1;
          pc_keep    = 1'b1;
          ifkeep     = 1'b1;
          idex_keep  = 1'b1;
          mem_done   = (cnt <= CW'(1));
          exmem_keep = (cnt > CW'(1));
        end
        default: ;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + CNT_W'(pc_keep);
      flush_q <= flush_q + CNT_W'(ifClear);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl with MEM_CYC=2 and MEM_CYC=3 instances
// compared to a cycle-count reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ex_memread = 1'b0;
  logic [3:0] ex_rd = '0;
  logic [3:0] id_rs = '0;
  logic       id_rs_use = 1'b0;
  logic [3:0] id_rt = '0;
  logic       id_rt_use = 1'b0;
  logic       branch_taken = 1'b0;
  logic       mem_req = 1'b0;

  logic [7:0]  o2, o3;
  logic [15:0] st2, fl2, st3, fl3;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(4), .MEM_CYC(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .id_rs(id_rs), .id_rs_use(id_rs_use), .id_rt(id_rt),
    .id_rt_use(id_rt_use), .branch_taken(branch_taken),
    .mem_req(mem_req), .pc_keep(o2[7]), .ifkeep(o2[6]),
    .ifClear(o2[5]), .idex_keep(o2[4]), .idex_clear(o2[3]),
    .exmem_keep(o2[2]), .ram_owner(o2[1]), .mem_done(o2[0]),
    .stall_cnt(st2), .flush_cnt(fl2)
  );

  hazard_ctrl #(.REG_W(4), .MEM_CYC(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .id_rs(id_rs), .id_rs_use(id_rs_use), .id_rt(id_rt),
    .id_rt_use(id_rt_use), .branch_taken(branch_taken),
    .mem_req(mem_req), .pc_keep(o3[7]), .ifkeep(o3[6]),
    .ifClear(o3[5]), .idex_keep(o3[4]), .idex_clear(o3[3]),
    .exmem_keep(o3[2]), .ram_owner(o3[1]), .mem_done(o3[0]),
    .stall_cnt(st3), .flush_cnt(fl3)
  );

  // Model: cycles of RAM ownership still to go, plus event tallies.
  int          left2 = 0, left3 = 0;
  logic [15:0] m_st2 = 0, m_fl2 = 0, m_st3 = 0, m_fl3 = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // {pc_keep,ifkeep,ifClear,idex_keep,idex_clear,exmem_keep,ram_owner,mem_done}
  function automatic logic [7:0] expect_out(input int left, input int mc);
    logic lu;
    logic done;
    lu = ex_memread && ((id_rs_use && ex_rd == id_rs) ||
                        (id_rt_use && ex_rd == id_rt));
    if (left > 0 || mem_req) begin
      done = (left > 0) ? (left == 1) : (mc == 1);
      return {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, !done, 1'b1, done};
    end
    if (lu) return 8'b1100_1000;
    if (branch_taken) return 8'b0010_0000;
    return 8'h00;
  endfunction

  function automatic int next_left(input int left, input int mc);
    if (left > 0) return left - 1;
    if (mem_req) return mc - 1;
    return 0;
  endfunction

  function automatic logic [15:0] exp_cnt(input logic [15:0] v);
`ifdef HAZ_PERF_CNT_EN
    return v;
`else
    return 16'h0 & v;
`endif
  endfunction

  // Called at a rising edge with inputs already applied.
  task automatic run_cycle();
    logic [7:0] e2, e3;
    int n2, n3;
    #1;
    e2 = expect_out(left2, 2);
    e3 = expect_out(left3, 3);
    chk("out_mc2", {24'h0, o2}, {24'h0, e2});
    chk("out_mc3", {24'h0, o3}, {24'h0, e3});
    chk("stall_mc2", {16'h0, st2}, {16'h0, exp_cnt(m_st2)});
    chk("flush_mc2", {16'h0, fl2}, {16'h0, exp_cnt(m_fl2)});
    chk("stall_mc3", {16'h0, st3}, {16'h0, exp_cnt(m_st3)});
    chk("flush_mc3", {16'h0, fl3}, {16'h0, exp_cnt(m_fl3)});
    n2 = next_left(left2, 2);
    n3 = next_left(left3, 3);
    @(negedge clk);
    left2 = n2;
    left3 = n3;
    m_st2 += 16'(e2[7]);
    m_fl2 += 16'(e2[5]);
    m_st3 += 16'(e3[7]);
    m_fl3 += 16'(e3[5]);
    @(posedge clk);
  endtask

  // Called at a rising edge; asserts reset mid-cycle and releases it later.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_out_mc2", {24'h0, o2}, 32'h0);
    chk("rst_out_mc3", {24'h0, o3}, 32'h0);
    chk("rst_cnt_mc2", {st2, fl2}, 32'h0);
    chk("rst_cnt_mc3", {st3, fl3}, 32'h0);
    left2 = 0; left3 = 0;
    m_st2 = 0; m_fl2 = 0; m_st3 = 0; m_fl3 = 0;
    @(negedge clk);
    @(posedge clk);
    rst = 1'b1;
  endtask

  task automatic set_in(input logic mr, input logic [3:0] rd,
                        input logic [3:0] rs, input logic rsu,
                        input logic [3:0] rt, input logic rtu,
                        input logic br, input logic mq);
    ex_memread = mr; ex_rd = rd; id_rs = rs; id_rs_use = rsu;
    id_rt = rt; id_rt_use = rtu; branch_taken = br; mem_req = mq;
  endtask

  initial begin
    @(posedge clk);
    do_reset();
    // Load-use on rs, then same pattern with rs unused.
    set_in(1, 3, 3, 1, 0, 0, 0, 0); run_cycle();
    set_in(1, 3, 3, 0, 0, 0, 0, 0); run_cycle();
    // Branch with no hazard.
    set_in(0, 0, 0, 0, 0, 0, 1, 0); run_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); run_cycle();
    // Held mem_req, then idle to let both instances drain.
    set_in(0, 0, 0, 0, 0, 0, 0, 1); run_cycle(); run_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); run_cycle(); run_cycle();
    // All three hazards together, then load-use alone.
    set_in(1, 5, 0, 0, 5, 1, 1, 1); run_cycle(); run_cycle();
    set_in(1, 5, 0, 0, 5, 1, 1, 0); run_cycle(); run_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); run_cycle(); run_cycle();
    // Reset in the second ownership cycle of the MEM_CYC=3 instance.
    set_in(0, 0, 0, 0, 0, 0, 0, 1); run_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mc3_in_access", {31'h0, o3[1]}, 32'h1);
    do_reset();
    run_cycle();
    chk("owner_after_rst", {31'h0, o3[1]}, 32'h0);
    // Perf scenario: 3 load-use stalls, one access, 2 branches.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 7, 7, 1, 0, 0, 0, 0); run_cycle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0); run_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 1); run_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); run_cycle(); run_cycle();
    run_cycle();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0); run_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
`ifdef HAZ_PERF_CNT_EN
    chk("perf_stall", {16'h0, st2}, 32'd5);
    chk("perf_flush", {16'h0, fl2}, 32'd2);
`else
    chk("perf_stall", {16'h0, st2}, 32'd0);
    chk("perf_flush", {16'h0, fl2}, 32'd0);
`endif
    @(posedge clk);
    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 60) == 0) do_reset();
      else run_cycle();
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
